// File: rtl/pattern_mask_detector.sv
`default_nettype none
// ============================================================================
// Module  : pattern_mask_detector
// Purpose : Serial detector comparing the last N enabled samples against a
//           run-time pattern with care mask, optional inverted-polarity
//           match, overlap control and a saturating match counter.
// Revision: 1.0 - initial release
// ============================================================================
module pattern_mask_detector #(
  parameter int N  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          x,
  input  logic [N-1:0]  pat,
  input  logic [N-1:0]  mask,
  input  logic          inv_ok,
  input  logic          ovl,
  input  logic          clr,
  output logic          y,
  output logic          y_q,
  output logic [CW-1:0] cnt
);

  localparam int              c_fw       = $clog2(N);
  localparam logic [c_fw-1:0] c_fill_max = c_fw'(N - 1);
  localparam logic [CW-1:0]   c_cnt_max  = {CW{1'b1}};

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-2:0]    r_hist;
  logic [c_fw-1:0] r_fill;
  logic [c_fw-1:0] w_fill_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_y_q;

  logic [N-1:0]    w_win;
  logic [N-1:0]    w_diff_pos;
  logic [N-1:0]    w_diff_neg;
  logic            w_hit;
  logic            w_y;

  // Window: previous samples followed by the bit presented this cycle.
  assign w_win      = {r_hist, x};
  assign w_diff_pos = (w_win ^ pat)  & mask;
  assign w_diff_neg = (w_win ^ ~pat) & mask;
  assign w_hit      = (w_diff_pos == '0) || (inv_ok && (w_diff_neg == '0));
  assign w_y        = en && (r_state == S_ARMED) && w_hit;

  always_comb begin
    w_fill_nxt  = r_fill;
    w_state_nxt = r_state;
    if (en) begin
      if (w_y && !ovl) begin
        // Non-overlap: the matched window is consumed entirely.
        w_fill_nxt  = '0;
        w_state_nxt = S_FILL;
      end else if (r_state == S_FILL) begin
        w_fill_nxt  = r_fill + c_fw'(1);
        w_state_nxt = (r_fill == c_fill_max - c_fw'(1)) ? S_ARMED : S_FILL;
      end
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (w_y && (r_cnt != c_cnt_max)) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
      r_fill  <= '0;
      r_hist  <= '0;
      r_cnt   <= '0;
      r_y_q   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      r_cnt   <= w_cnt_nxt;
      r_y_q   <= w_y;
      if (en) begin
        r_hist <= w_win[N-2:0];
      end
    end
  end

  assign y   = w_y;
  assign y_q = r_y_q;
  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pattern_mask_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_pattern_mask_detector
// Purpose : Self-checking bench for pattern_mask_detector (three configs).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pattern_mask_detector;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, x, inv_ok, ovl, clr;
  logic [15:0] pat_v [3];
  logic [15:0] mask_v[3];
  wire  [2:0]  y_v, yq_v;
  wire  [7:0]  cnt0, cnt1;
  wire  [1:0]  cnt2;
  logic [2:0]  ys_o;

  pattern_mask_detector #(.N(3), .CW(8)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat(pat_v[0][2:0]), .mask(mask_v[0][2:0]),
    .inv_ok(inv_ok), .ovl(ovl), .clr(clr), .y(y_v[0]), .y_q(yq_v[0]), .cnt(cnt0));
  pattern_mask_detector #(.N(4), .CW(8)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat(pat_v[1][3:0]), .mask(mask_v[1][3:0]),
    .inv_ok(inv_ok), .ovl(ovl), .clr(clr), .y(y_v[1]), .y_q(yq_v[1]), .cnt(cnt1));
  pattern_mask_detector #(.N(2), .CW(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat(pat_v[2][1:0]), .mask(mask_v[2][1:0]),
    .inv_ok(inv_ok), .ovl(ovl), .clr(clr), .y(y_v[2]), .y_q(yq_v[2]), .cnt(cnt2));

  // Reference model: sample history plus count of fresh samples since the
  // last reset or consumed (non-overlap) match.
  int          c_n   [3] = '{3, 4, 2};
  int          c_cmax[3] = '{255, 255, 3};
  logic [15:0] m_hist [3];
  int          m_fresh[3];
  int          m_cnt  [3];
  logic        m_yq   [3];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic x;
    logic ey;
    int   ecnt;
  } vec_t;
  vec_t axa[7];

  function automatic logic [31:0] dut_cnt(int k);
    case (k)
      0:       return {24'd0, cnt0};
      1:       return {24'd0, cnt1};
      default: return {30'd0, cnt2};
    endcase
  endfunction

  function automatic logic model_y(int k);
    logic [15:0] win;
    bit          pos, neg;
    if (!rst || !en || m_fresh[k] < c_n[k] - 1) return 1'b0;
    win = {m_hist[k][14:0], x};
    pos = 1'b1;
    neg = 1'b1;
    for (int i = 0; i < c_n[k]; i++) begin
      if (mask_v[k][i]) begin
        if (win[i] !== pat_v[k][i]) pos = 1'b0;
        else                        neg = 1'b0;
      end
    end
    return pos || (inv_ok && neg);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_hist[k]  = '0;
      m_fresh[k] = 0;
      m_cnt[k]   = 0;
      m_yq[k]    = 1'b0;
    end
  endtask

  task automatic model_update();
    logic yy;
    for (int k = 0; k < 3; k++) begin
      yy      = model_y(k);
      m_yq[k] = yy;
      if (clr)                          m_cnt[k] = 0;
      else if (yy && m_cnt[k] < c_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
      if (en) begin
        m_hist[k] = {m_hist[k][14:0], x};
        if (yy && !ovl)         m_fresh[k] = 0;
        else if (m_fresh[k] < 64) m_fresh[k] = m_fresh[k] + 1;
      end
    end
  endtask

  // One clock: check y before the edge, y_q/cnt just after it.
  task automatic cyc(output logic [2:0] ys);
    #2;
    ys = y_v;
    for (int k = 0; k < 3; k++) chk($sformatf("y[%0d]", k), {31'd0, y_v[k]}, {31'd0, model_y(k)});
    @(posedge clk);
    model_update();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("y_q[%0d]", k), {31'd0, yq_v[k]}, {31'd0, m_yq[k]});
      chk($sformatf("cnt[%0d]", k), dut_cnt(k), m_cnt[k]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_y[%0d]", k), {31'd0, y_v[k]}, 0);
      chk($sformatf("rst_yq[%0d]", k), {31'd0, yq_v[k]}, 0);
      chk($sformatf("rst_cnt[%0d]", k), dut_cnt(k), 0);
    end
    model_reset();
    #1;
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    cyc(ys_o);
  endtask

  task automatic feed(input logic b);
    en = 1'b1;
    x  = b;
    cyc(ys_o);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; x = 1'b0; inv_ok = 1'b0; ovl = 1'b1; clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pat_v[k]  = '0;
      mask_v[k] = '0;
    end
    model_reset();
    axa[0] = '{1'b0, 1'b0, 0};
    axa[1] = '{1'b1, 1'b0, 0};
    axa[2] = '{1'b0, 1'b1, 1};
    axa[3] = '{1'b1, 1'b1, 2};
    axa[4] = '{1'b1, 1'b0, 2};
    axa[5] = '{1'b1, 1'b1, 3};
    axa[6] = '{1'b0, 1'b0, 3};

    // A-X-A on the N=3 instance
    pat_v[0] = 16'b101; mask_v[0] = 16'b101; inv_ok = 1'b1; ovl = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      feed(axa[i].x);
      chk("axa_y", {31'd0, ys_o[0]}, {31'd0, axa[i].ey});
      chk("axa_yq", {31'd0, yq_v[0]}, {31'd0, axa[i].ey});
      chk("axa_cnt", {24'd0, cnt0}, axa[i].ecnt);
    end

    // Same stream with idle cycles between samples
    do_reset();
    for (int i = 0; i < 7; i++) begin
      feed(axa[i].x);
      chk("gap_y", {31'd0, ys_o[0]}, {31'd0, axa[i].ey});
      en = 1'b0;
      x  = 1'($urandom_range(0, 1));
      cyc(ys_o);
      chk("gap_idle_y", {31'd0, ys_o[0]}, 0);
    end
    chk("gap_cnt", {24'd0, cnt0}, 3);

    // Overlap vs non-overlap on the N=4 instance
    pat_v[1] = 16'b1010; mask_v[1] = 16'b1111; inv_ok = 1'b0;
    for (int m = 0; m < 2; m++) begin
      ovl = (m == 0);
      do_reset();
      for (int i = 0; i < 6; i++) begin
        feed(i[0] ? 1'b0 : 1'b1);
        chk("ovl_y", {31'd0, ys_o[1]}, {31'd0, (i == 3) || (ovl && i == 5)});
      end
      chk("ovl_cnt", {24'd0, cnt1}, ovl ? 2 : 1);
    end

    // Polarity-agnostic match
    pat_v[0] = 16'b110; mask_v[0] = 16'b111; ovl = 1'b1;
    for (int m = 0; m < 2; m++) begin
      inv_ok = m[0];
      do_reset();
      feed(1'b0);
      chk("pol_y0", {31'd0, ys_o[0]}, 0);
      feed(1'b0);
      chk("pol_y1", {31'd0, ys_o[0]}, 0);
      feed(1'b1);
      chk("pol_y2", {31'd0, ys_o[0]}, m);
    end

    // Saturation and clear priority on the N=2, CW=2 instance
    mask_v[2] = '0; inv_ok = 1'b0;
    do_reset();
    feed(1'b1);
    chk("sat_warm", {30'd0, cnt2}, 0);
    for (int i = 0; i < 5; i++) begin
      feed(1'($urandom_range(0, 1)));
      chk("sat_cnt", {30'd0, cnt2}, (i + 1 > 3) ? 3 : i + 1);
    end
    clr = 1'b1;
    feed(1'b0);
    chk("clr_match_y", {31'd0, ys_o[2]}, 1);
    chk("clr_cnt", {30'd0, cnt2}, 0);
    clr = 1'b0;

    // Asynchronous reset in the middle of a stream
    mask_v[0] = '0;
    do_reset();
    for (int i = 0; i < 7; i++) feed(1'b1);
    chk("mid_cnt", {24'd0, cnt0}, 5);
    en = 1'b1; x = 1'b1;
    #2;
    chk("mid_pre_y", {31'd0, y_v[0]}, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      feed(1'b1);
      chk("mid_post_y", {31'd0, ys_o[0]}, (i == 2) ? 1 : 0);
    end

    // Randomised traffic against the model
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int k = 0; k < 3; k++) begin
          pat_v[k]  = 16'($urandom);
          mask_v[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        end
        inv_ok = 1'($urandom_range(0, 1));
        ovl    = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        en  = ($urandom_range(0, 3) != 0);
        x   = 1'($urandom_range(0, 1));
        clr = ($urandom_range(0, 39) == 0);
        cyc(ys_o);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_mask_detector.md
# pattern_mask_detector

Parametrised serial pattern detector for the bit-stream pattern detectors library. It compares the last N sampled bits of a serial input against a run-time pattern, with a per-bit care mask and an optional polarity-agnostic match. It reports matches combinationally (Mealy) and registered, and keeps a saturating match counter. An A-X-A detector is one configuration of this block: N=3, pat=3'b101, mask=3'b101, inv_ok=1.

## Interface
- N, default 3: pattern length in bits; legal range 2..16.
- CW, default 8: match counter width in bits.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sample strobe; x is consumed only on edges where en=1.
- x  in  1  serial data bit.
- pat  in  N  pattern; pat[N-1] is the oldest bit, pat[0] is the current bit.
- mask  in  N  care mask; 1 = compare this position, 0 = don't-care.
- inv_ok  in  1  1 = accept a match against pat or ~pat over the masked positions.
- ovl  in  1  1 = overlapping detection; 0 = non-overlapping.
- clr  in  1  synchronous clear of the match counter.
- y  out  1  Mealy match: the current x completes a match this cycle.
- y_q  out  1  y registered; equals the value of y on the previous edge.
- cnt  out  CW  saturating count of matches.

## Operation
- State:
  - hist[N-2:0]: shift register holding the previous sampled bits; hist[0] is the most recent.
  - fill: fill counter, 0..N-1, saturating at N-1.
  - cnt
  - y_q
- FSM view of fill:
  - FILL while fill < N-1.
  - ARMED when fill == N-1.
- Window: w = {hist[N-2:0], x}.
- Matching:
  - d = (w ^ pat) & mask.
  - hit = (d == 0) or (inv_ok and ((w ^ ~pat) & mask) == 0).
  - y = en & ARMED & hit; purely combinational.
- On an edge with en=1:
  - hist shifts left and takes x into hist[0].
  - If y=1 and ovl=0: fill <= 0. The bits of the matched window are never reused; the next match needs N fresh bits.
  - Otherwise fill increments, saturating at N-1.
- On an edge with en=0: hist, fill and cnt hold. y is 0.
- Counter:
  - clr=1: cnt <= 0. clr takes priority over a simultaneous match.
  - Else if y=1 and cnt != all-ones: cnt <= cnt+1.
  - At all-ones, cnt holds (saturates).
- y_q <= y on every edge, including edges where en=0.
- Configuration (pat, mask, inv_ok, ovl) is not registered and affects y in the same cycle. A mid-stream change does not flush hist or fill.
- mask = 0 with ARMED: every enabled sample matches.

## Timing
- Reset values: hist=0, fill=0 (FILL state), cnt=0, y_q=0. y=0 while rst is low.
- Reset mid-stream discards history. After release, the first possible match is on the Nth enabled sample.
- Latency:
  - y asserts in the same cycle the completing bit is presented with en=1.
  - cnt updates at that edge.
  - y_q asserts one cycle later.
- Overlap mode: in a run of matches, y can assert on consecutive enabled samples.
- Non-overlap mode: at least N enabled samples separate two y pulses.
- Gaps in en are transparent: the window is built only from enabled samples.

## Test plan
- A-X-A (N=3, pat=101, mask=101, inv_ok=1, ovl=1), x=0,1,0,1,1,1,0 with en=1 every cycle:
  - y=0,0,1,1,0,1,0.
  - cnt ends at 3.
  - y_q equals y delayed by one cycle.
- Overlap vs non-overlap (N=4, pat=1010, mask=1111, inv_ok=0), x=1,0,1,0,1,0:
  - ovl=1: y pulses on samples 4 and 6, cnt=2.
  - ovl=0: y pulses on sample 4 only, cnt=1.
- en gaps: the same stream as the A-X-A case, with en=0 cycles inserted between every sample, gives an identical y pattern on the enabled cycles, y=0 on gap cycles, and the same final cnt.
- Saturation and clear (CW=2, mask=0, N=2): after 1 warm-up sample, 5 more enabled samples:
  - cnt goes 1,2,3,3,3.
  - clr asserted together with a match: next cnt=0.
- Reset mid-operation: assert rst low with fill=N-1 and cnt=5:
  - All outputs drop to 0 immediately.
  - After release, no y pulse before the Nth enabled sample, even if the pattern bits are present.
- Polarity (N=3, pat=110, mask=111), input bits 001:
  - inv_ok=0: y=0.
  - inv_ok=1: y=1 on the third bit.
